wakeup_wheel: RTL
=================

Name: wakeup_wheel

Overview:
- Producer of the 4-tag wakeup broadcast bus (`wdest4x`) consumed by the issue queue and its issue slots.
- Accepts up to 2 issued ops per cycle (one per issue lane), each with destination physical register, execution latency and branch mask.
- Reserves a writeback slot on a per-lane completion wheel and broadcasts each destination exactly L cycles after issue.
- Squashes ops killed by branch resolution; rejects issues (replay) when the target completion cycle is full.

Parameters:
- WIDTH_REG, 5, physical register tag width.
- WIDTH_BRM, 3, branch mask width.
- MAX_LAT, 4, maximum execution latency in cycles (>=1).
- LAT_W, 3, latency field width; must hold MAX_LAT.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_en  in  1  advance enable; low = wheel frozen.
- i_valid  in  2  issue valid, bit j = lane j.
- i_wdest  in  2*WIDTH_REG  destination tag, lane j at [j*WIDTH_REG +: WIDTH_REG].
- i_lat  in  2*LAT_W  latency, lane j at [j*LAT_W +: LAT_W].
- i_brmask  in  2*WIDTH_BRM  branch mask of issued op.
- i_BrKill  in  WIDTH_BRM  kill mask; any overlap with an op's mask squashes it.
- o_wdest4x  out  4*WIDTH_REG  broadcast; field 2j+s = lane j slot s; 0 = no broadcast.
- o_replay  out  2  combinational; op on lane j not accepted, must be reissued.

Behaviour:
- Clock and reset:
  - One clock, i_clk.
  - Reset is asynchronous and active-high (i_rst).
  - On reset, every wheel entry is invalid, o_wdest4x = 0 and o_replay = 0.
- Wheel structure:
  - Per lane, positions 1..MAX_LAT, each with 2 slots {valid, dest, brmask}.
  - Position 1 is the output register: o_wdest4x field = dest if valid, else 0.
- Each edge with i_en=1:
  - pos[k] <= pos[k+1] for k < MAX_LAT; pos[MAX_LAT] <= empty.
  - The accepted new op is then written into pos[L].
  - Result: an op issued in cycle t with latency L is broadcast during cycle t+L, for exactly one cycle.
- Slot selection:
  - Compare against the pre-shift occupancy of pos[L+1] (pos[MAX_LAT+1] = empty).
  - Use slot 0 if free, else slot 1.
  - If both are occupied, raise o_replay[j] and insert nothing.
- Acceptance rules:
  - i_valid[j]=0: no action, o_replay[j]=0.
  - Dest 0 or lat 0: accepted with nothing inserted, o_replay=0.
  - lat > MAX_LAT: o_replay=1, not inserted.
- Lanes are independent; both lanes may insert in the same cycle with no cross-lane interaction.
- Branch kill:
  - On any edge, every entry with (brmask & i_BrKill) != 0 is invalidated. This includes position 1, whose broadcast vanishes next cycle, and applies regardless of i_en.
  - An incoming op whose own mask overlaps i_BrKill is dropped silently (o_replay=0).
  - Kill is applied after the shift, to the shifted contents.
- i_en=0:
  - Wheel holds (kill still applies).
  - o_wdest4x keeps its current value.
  - Every valid incoming op gets o_replay=1.
- o_replay depends only on current inputs and wheel state (no i_BrKill dependence, apart from the i_en=0 case and the masked-drop rule above).
- Reset asserted mid-operation clears all in-flight ops immediately; no broadcast is emitted after reset release for pre-reset issues.

Decomposition:
- Shared package (e.g. core_pkg):
  - WIDTH_REG, WIDTH_BRM, MAX_LAT, LAT_W defaults.
  - Wheel-entry struct/field offsets {valid, dest, brmask}, also shared with the issue-queue packing.
- Sub-module wakeup_lane_wheel, instantiated twice:
  - Inputs: one lane's insert port, kill, en.
  - Outputs: its 2 broadcast tags and its replay bit.
- Top level: lane wiring and o_wdest4x concatenation.

Test Plan:
- Reset then lane0 valid, dest=7, lat=3 at cycle 0 -> o_wdest4x field0 = 7 during cycle 3 only; all other fields 0; o_replay=0.
- Lane0 lat=4 dest=5 at t0, lat=3 dest=6 at t1, lat=2 dest=9 at t2 -> t4 field0=5, field1=6; dest=9 gets o_replay[0]=1 at t2 and never broadcasts.
- Lane1 dest=12 lat=2 brmask=3'b010 at t0, i_BrKill=3'b010 at t1 -> no broadcast in t2.
- Same dest=12 op, i_BrKill=3'b100 -> field2=12 in t2.
- i_en=0 for 2 cycles after issuing dest=4 lat=1, with a second valid op arriving meanwhile -> broadcast of 4 stretches across the stall; the new op sees o_replay=1.
- lat=0 or dest=0 -> no broadcast, no replay.
- lat=5 (> MAX_LAT=4) -> o_replay=1.
- i_rst pulsed mid-flight with 4 ops queued -> o_wdest4x=0 immediately; no stale broadcasts afterwards.

Source files
------------

// File: rtl/wakeup_wheel_pkg.sv
// Shared constants and wheel-entry layout for the wakeup broadcast wheel.
// The entry field offsets are also used when packing issue-queue wakeup state.
package wakeup_wheel_pkg;

  localparam int DEF_WIDTH_REG = 5;
  localparam int DEF_WIDTH_BRM = 3;
  localparam int DEF_MAX_LAT   = 4;
  localparam int DEF_LAT_W     = 3;

  typedef struct packed {
    logic                     valid;
    logic [DEF_WIDTH_REG-1:0] dest;
    logic [DEF_WIDTH_BRM-1:0] brmask;
  } wheel_ent_t;

  localparam int ENT_BRM_LSB   = 0;
  localparam int ENT_DEST_LSB  = DEF_WIDTH_BRM;
  localparam int ENT_VALID_BIT = DEF_WIDTH_BRM + DEF_WIDTH_REG;
  localparam int ENT_W         = DEF_WIDTH_BRM + DEF_WIDTH_REG + 1;

endpackage

// File: rtl/wakeup_lane_wheel.sv
// One issue lane's completion wheel: positions 1..MAX_LAT x 2 slots, position 1
// drives the lane's two broadcast tags.
module wakeup_lane_wheel
  import wakeup_wheel_pkg::*;
#(
  parameter int WIDTH_REG = DEF_WIDTH_REG,
  parameter int WIDTH_BRM = DEF_WIDTH_BRM,
  parameter int MAX_LAT   = DEF_MAX_LAT,
  parameter int LAT_W     = DEF_LAT_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_valid,
  input  logic [WIDTH_REG-1:0]   i_wdest,
  input  logic [LAT_W-1:0]       i_lat,
  input  logic [WIDTH_BRM-1:0]   i_brmask,
  input  logic [WIDTH_BRM-1:0]   i_BrKill,
  output logic [2*WIDTH_REG-1:0] o_wdest2,
  output logic                   o_replay
);

  typedef struct packed {
    logic                 valid;
    logic [WIDTH_REG-1:0] dest;
    logic [WIDTH_BRM-1:0] brmask;
  } ent_t;

  ent_t       r_pos [MAX_LAT][2];
  ent_t       w_nxt [MAX_LAT][2];
  logic [1:0] w_occ;
  logic       w_ins;
  logic       w_slot;
  logic       w_kill_in;

  // Occupancy of pos[L+1] before the shift, i.e. what lands in pos[L].
  always_comb begin
    w_occ = '0;
    for (int k = 1; k < MAX_LAT; k++)
      if (i_lat == LAT_W'(k)) w_occ = {r_pos[k][1].valid, r_pos[k][0].valid};
  end

  assign w_kill_in = |(i_brmask & i_BrKill);
  assign w_slot    = w_occ[0];

  always_comb begin
    o_replay = 1'b0;
    w_ins    = 1'b0;
    if (i_valid) begin
      if (!i_en)                                 o_replay = 1'b1;
      else if (i_wdest == '0 || i_lat == '0)     o_replay = 1'b0;
      else if (i_lat > LAT_W'(MAX_LAT))          o_replay = 1'b1;
      else if (w_kill_in)                        o_replay = 1'b0;
      else if (&w_occ)                           o_replay = 1'b1;
      else                                       w_ins    = 1'b1;
    end
  end

  always_comb begin
    for (int k = 0; k < MAX_LAT; k++)
      for (int s = 0; s < 2; s++) w_nxt[k][s] = r_pos[k][s];
    if (i_en) begin
      for (int k = 0; k < MAX_LAT-1; k++)
        for (int s = 0; s < 2; s++) w_nxt[k][s] = r_pos[k+1][s];
      w_nxt[MAX_LAT-1][0] = '0;
      w_nxt[MAX_LAT-1][1] = '0;
      if (w_ins)
        for (int k = 0; k < MAX_LAT; k++)
          if (i_lat == LAT_W'(k+1))
            w_nxt[k][w_slot] = '{valid: 1'b1, dest: i_wdest, brmask: i_brmask};
    end
    // Kill sees post-shift contents, and is applied even while frozen.
    for (int k = 0; k < MAX_LAT; k++)
      for (int s = 0; s < 2; s++)
        if (|(w_nxt[k][s].brmask & i_BrKill)) w_nxt[k][s].valid = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_pos <= '{default: '0};
    else       r_pos <= w_nxt;
  end

  for (genvar s = 0; s < 2; s++) begin : g_out
    assign o_wdest2[s*WIDTH_REG +: WIDTH_REG] = r_pos[0][s].valid ? r_pos[0][s].dest : '0;
  end

endmodule

// File: rtl/wakeup_wheel.sv
// Two-lane wakeup wheel producing the 4-tag wakeup broadcast bus.
// Field 2j+s of o_wdest4x is lane j, slot s.
module wakeup_wheel
  import wakeup_wheel_pkg::*;
#(
  parameter int WIDTH_REG = DEF_WIDTH_REG,
  parameter int WIDTH_BRM = DEF_WIDTH_BRM,
  parameter int MAX_LAT   = DEF_MAX_LAT,
  parameter int LAT_W     = DEF_LAT_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic [1:0]             i_valid,
  input  logic [2*WIDTH_REG-1:0] i_wdest,
  input  logic [2*LAT_W-1:0]     i_lat,
  input  logic [2*WIDTH_BRM-1:0] i_brmask,
  input  logic [WIDTH_BRM-1:0]   i_BrKill,
  output logic [4*WIDTH_REG-1:0] o_wdest4x,
  output logic [1:0]             o_replay
);

  for (genvar j = 0; j < 2; j++) begin : g_lane
    wakeup_lane_wheel #(
      .WIDTH_REG (WIDTH_REG),
      .WIDTH_BRM (WIDTH_BRM),
      .MAX_LAT   (MAX_LAT),
      .LAT_W     (LAT_W)
    ) u_lane (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_en     (i_en),
      .i_valid  (i_valid[j]),
      .i_wdest  (i_wdest[j*WIDTH_REG +: WIDTH_REG]),
      .i_lat    (i_lat[j*LAT_W +: LAT_W]),
      .i_brmask (i_brmask[j*WIDTH_BRM +: WIDTH_BRM]),
      .i_BrKill (i_BrKill),
      .o_wdest2 (o_wdest4x[j*2*WIDTH_REG +: 2*WIDTH_REG]),
      .o_replay (o_replay[j])
    );
  end

endmodule
